// File: rtl/dut_probe_engine.sv
// Probe engine: drives and observes N_CH channels of W bits through a command/response handshake.
// SET/GET/BAD_CMD answer one cycle after accept; waits sit in EXEC until condition, abort or timeout.
module dut_probe_engine #(
  parameter int N_CH = 8,
  parameter int W    = 32,
  parameter int TW   = 16,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int BW  = (W > 1) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [BW-1:0]     cmd_bit,
  input  logic [W-1:0]      cmd_data,
  input  logic [TW-1:0]     cmd_timeout,
  input  logic              abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [1:0]        rsp_status,
  output logic [N_CH*W-1:0] drv_o,
  input  logic [N_CH*W-1:0] obs_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd1;
  localparam logic [2:0] OP_WEQ  = 3'd2;
  localparam logic [2:0] OP_WPOS = 3'd3;
  localparam logic [2:0] OP_WNEG = 3'd4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD     = 2'd2;
  localparam logic [1:0] ST_ABORTED = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      drv_q [N_CH];
  logic [W-1:0]      drv_d [N_CH];
  logic [N_CH*W-1:0] obs_q, obs_d;
  logic [W-1:0]      rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [2:0]        op_q, op_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [W-1:0]      data_q, data_d;

  logic [W-1:0]      obs_ch   [N_CH];
  logic [W-1:0]      obs_prev [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign obs_ch[c]          = obs_i[c*W +: W];
    assign obs_prev[c]        = obs_q[c*W +: W];
    assign drv_o[c*W +: W]    = drv_q[c];
  end

  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;

  // Command legality; the channel index is forced to 0 when out of range so no array read goes out of bounds.
  logic           op_ok, ch_ok, bit_ok, is_edge_op, cmd_legal;
  logic [CHW-1:0] cmd_ch_s;

  always_comb begin
    op_ok      = (cmd_op <= OP_WNEG);
    ch_ok      = (int'(cmd_ch) < N_CH);
    bit_ok     = (int'(cmd_bit) < W);
    is_edge_op = (cmd_op == OP_WPOS) || (cmd_op == OP_WNEG);
    cmd_legal  = op_ok && ch_ok && (!is_edge_op || bit_ok);
    cmd_ch_s   = ch_ok ? cmd_ch : '0;
  end

  logic [W-1:0] cur_val, prv_val;
  logic         cond_hit, tmo_hit;

  always_comb begin
    cur_val  = obs_ch[ch_q];
    prv_val  = obs_prev[ch_q];
    cond_hit = 1'b0;
    case (op_q)
      OP_WEQ:  cond_hit = (cur_val == data_q);
      OP_WPOS: cond_hit = cur_val[bit_q] && !prv_val[bit_q];
      OP_WNEG: cond_hit = !cur_val[bit_q] && prv_val[bit_q];
      default: cond_hit = 1'b0;
    endcase
    tmo_hit = (tmo_q != '0) && (cnt_q == tmo_q - TW'(1));
  end

  always_comb begin
    state_d      = state_q;
    drv_d        = drv_q;
    obs_d        = obs_i;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    op_d         = op_q;
    ch_d         = ch_q;
    bit_d        = bit_q;
    data_d       = data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d      = S_RESP;
          rsp_status_d = ST_OK;
          rsp_data_d   = '0;
          if (!cmd_legal) begin
            rsp_status_d = ST_BAD;
          end else begin
            case (cmd_op)
              OP_SET: drv_d[cmd_ch_s] = cmd_data;
              OP_GET: rsp_data_d      = obs_ch[cmd_ch_s];
              default: begin
                op_d    = cmd_op;
                ch_d    = cmd_ch_s;
                bit_d   = cmd_bit;
                data_d  = cmd_data;
                tmo_d   = cmd_timeout;
                cnt_d   = '0;
                state_d = S_EXEC;
              end
            endcase
          end
        end
      end

      // Priority: a met condition beats abort, which beats timeout.
      S_EXEC: begin
        if (cond_hit) begin
          state_d      = S_RESP;
          rsp_status_d = ST_OK;
          rsp_data_d   = cur_val;
        end else if (abort) begin
          state_d      = S_RESP;
          rsp_status_d = ST_ABORTED;
          rsp_data_d   = cur_val;
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = cur_val;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drv_q        <= '{default: '0};
      obs_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      cnt_q        <= '0;
      tmo_q        <= '0;
      op_q         <= '0;
      ch_q         <= '0;
      bit_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      drv_q        <= drv_d;
      obs_q        <= obs_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      op_q         <= op_d;
      ch_q         <= ch_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_dut_probe_engine.sv
// Randomised scoreboard bench for dut_probe_engine, plus a narrow instance (N_CH=3, W=12) whose
// channel and bit fields can encode out-of-range values.
module tb_dut_probe_engine;
  localparam int NC = 6, WD = 32, TWD = 16;
  localparam int SNC = 3, SW = 12, STW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [2:0]        cmd_ch = '0;
  logic [4:0]        cmd_bit = '0;
  logic [31:0]       cmd_data = '0;
  logic [15:0]       cmd_timeout = '0;
  logic              abort = 1'b0;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_status;
  logic [NC*WD-1:0]  drv_o;
  logic [NC*WD-1:0]  obs_i = '0;

  logic              s_cmd_valid = 1'b0, s_cmd_ready;
  logic [2:0]        s_cmd_op = '0;
  logic [1:0]        s_cmd_ch = '0;
  logic [3:0]        s_cmd_bit = '0;
  logic [11:0]       s_cmd_data = '0;
  logic [7:0]        s_cmd_timeout = '0;
  logic              s_rsp_valid;
  logic [11:0]       s_rsp_data;
  logic [1:0]        s_rsp_status;
  logic [SNC*SW-1:0] s_drv_o;
  logic [SNC*SW-1:0] s_obs_i = '0;

  dut_probe_engine #(.N_CH(NC), .W(WD), .TW(TWD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_bit(cmd_bit), .cmd_data(cmd_data), .cmd_timeout(cmd_timeout),
    .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .drv_o(drv_o), .obs_i(obs_i));

  dut_probe_engine #(.N_CH(SNC), .W(SW), .TW(STW)) dut_s (
    .clk(clk), .rst(rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
    .cmd_ch(s_cmd_ch), .cmd_bit(s_cmd_bit), .cmd_data(s_cmd_data), .cmd_timeout(s_cmd_timeout),
    .abort(1'b0), .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_data(s_rsp_data),
    .rsp_status(s_rsp_status), .drv_o(s_drv_o), .obs_i(s_obs_i));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]       st;
    logic [31:0]      dat;
    int               lat;
    int               acc;
    logic [NC*WD-1:0] drv;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] drv_m [NC];
  logic [31:0] sched [0:255];
  int          sched_len;
  int          n_tests = 0, n_fail = 0;
  int          hold_cycles = 0;
  bit          seen_rise = 0, stalled = 0;
  logic [31:0] st_dat;
  logic [1:0]  st_st;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [NC*WD-1:0] drv_pack();
    logic [NC*WD-1:0] v;
    for (int c = 0; c < NC; c++) v[c*WD +: WD] = drv_m[c];
    return v;
  endfunction

  task automatic obs_drive(input int ch, input logic [31:0] v);
    for (int c = 0; c < NC; c++) obs_i[c*WD +: WD] = $urandom;
    if (ch < NC) obs_i[ch*WD +: WD] = v;
  endtask

  // Monitor: randomly back-pressures, checks hold-while-stalled, pops on each response handshake.
  initial begin
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0; seen_rise = 0; rsp_ready = 1'b0;
        continue;
      end
      if (hold_cycles > 0) begin
        rsp_ready = 1'b0;
        hold_cycles--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (stalled) begin
        chk("rsp_hold_valid", rsp_valid, 1'b1);
        chk("rsp_hold_payload", {rsp_status, rsp_data}, {st_st, st_dat});
      end
      stalled = 0;
      if (rsp_valid) begin
        chk("cmd_ready_while_rsp", cmd_ready, 1'b0);
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got status %0d data %0h, expected no response", rsp_status, rsp_data);
        end else begin
          if (!seen_rise) begin
            chk("rsp_latency", cyc - sbq[0].acc, sbq[0].lat);
            seen_rise = 1;
          end
          if (rsp_ready) begin
            e = sbq.pop_front();
            chk("rsp_status", rsp_status, e.st);
            chk("rsp_data", rsp_data, e.dat);
            chk("drv_o", drv_o, e.drv);
            seen_rise = 0;
          end else begin
            stalled = 1; st_st = rsp_status; st_dat = rsp_data;
          end
        end
      end
    end
  end

  // Reference: walks the planned channel waveform edge by edge using the command's rules.
  task automatic run_cmd(input logic [2:0] op, input int ch, input int bitn, input logic [31:0] data,
                         input logic [15:0] tmo, input int abort_at);
    exp_t        e;
    logic [31:0] cv, pv;
    bit          hit;
    int          guard;
    e.st = 2'd0; e.dat = '0; e.lat = 0;
    if (op > 3'd4 || ch >= NC) begin
      e.st = 2'd2;
    end else if (op == 3'd0) begin
      drv_m[ch] = data;
    end else if (op == 3'd1) begin
      e.dat = sched[0];
    end else begin
      for (int j = 1; j <= sched_len && e.lat == 0; j++) begin
        cv = sched[j]; pv = sched[j-1];
        hit = (op == 3'd2) ? (cv == data) :
              (op == 3'd3) ? (cv[bitn] && !pv[bitn]) : (!cv[bitn] && pv[bitn]);
        if (hit) begin e.st = 2'd0; e.lat = j; end
        else if (j == abort_at) begin e.st = 2'd3; e.lat = j; end
        else if (tmo != 0 && j == int'(tmo)) begin e.st = 2'd1; e.lat = j; end
        if (e.lat != 0) e.dat = cv;
      end
    end
    e.drv = drv_pack();

    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 3000) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, expected 1", guard);
      return;
    end
    cmd_op = op; cmd_ch = 3'(ch); cmd_bit = 5'(bitn); cmd_data = data; cmd_timeout = tmo;
    abort = $urandom_range(0, 1);
    obs_drive(ch, sched[0]);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.acc = cyc;
    sbq.push_back(e);
    for (int j = 1; j <= e.lat; j++) begin
      obs_drive(ch, sched[j]);
      abort = (j == abort_at);
      @(posedge clk); #1;
    end
    abort = (abort_at > e.lat);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !cmd_ready) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", sbq.size());
    end
  endtask

  task automatic s_cmd(input logic [2:0] op, input logic [1:0] ch, input logic [3:0] bitn,
                       input logic [11:0] data, input logic [7:0] tmo, input logic [1:0] req_st,
                       input int req_lat);
    int                n;
    logic [SNC*SW-1:0] req_drv;
    @(negedge clk);
    n = 0;
    while (!s_cmd_ready && n < 100) begin @(negedge clk); n++; end
    req_drv = s_drv_o;
    if (op == 3'd0 && int'(ch) < SNC) req_drv[int'(ch)*SW +: SW] = data;
    s_cmd_op = op; s_cmd_ch = ch; s_cmd_bit = bitn; s_cmd_data = data; s_cmd_timeout = tmo;
    s_cmd_valid = 1'b1;
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!s_rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("s_latency", n, req_lat);
    chk("s_status", s_rsp_status, req_st);
    chk("s_data", s_rsp_data, 12'h0);
    chk("s_drv", s_drv_o, req_drv);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  r_op;
  int          r_ch, r_bit, r_ab, sel;
  logic [31:0] r_data;
  logic [15:0] r_tmo;

  initial begin
    for (int c = 0; c < NC; c++) drv_m[c] = '0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_drv", drv_o, '0);
    chk("rst_rsp", {rsp_status, rsp_data}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    sched_len = 1; sched[0] = '0; sched[1] = '0;
    run_cmd(3'd0, 2, 0, 32'hDEAD_BEEF, 16'd0, 0);
    sched[0] = 32'h0000_00A5;
    run_cmd(3'd1, 5, 0, 32'h0, 16'd0, 0);

    sched_len = 20;
    for (int k = 0; k <= 20; k++) sched[k] = (k >= 4) ? 32'd7 : 32'd0;
    run_cmd(3'd2, 1, 0, 32'd7, 16'd10, 0);
    for (int k = 0; k <= 20; k++) sched[k] = 32'd3;
    run_cmd(3'd2, 1, 0, 32'd7, 16'd10, 0);
    for (int k = 0; k <= 20; k++) sched[k] = (k >= 4) ? 32'h55 : 32'h0;
    run_cmd(3'd2, 4, 0, 32'h55, 16'd4, 0);
    for (int k = 0; k <= 20; k++) sched[k] = 32'h1;
    run_cmd(3'd2, 0, 0, 32'h1, 16'd1, 0);

    sched_len = 120;
    for (int k = 0; k <= 120; k++) sched[k] = ((k >= 100) ? 32'h8000_0000 : 32'h0) | ($urandom & 32'h7FFF_FFFF);
    run_cmd(3'd3, 0, 31, 32'h0, 16'd0, 0);
    sched_len = 20;
    for (int k = 0; k <= 20; k++) sched[k] = 32'hFFFF_FFFF;
    run_cmd(3'd4, 3, 5, 32'h0, 16'd0, 3);
    for (int k = 0; k <= 20; k++) sched[k] = (k >= 1) ? 32'h10 : 32'h0;
    run_cmd(3'd3, 2, 4, 32'h0, 16'd0, 0);

    run_cmd(3'd6, 0, 0, 32'h1111_2222, 16'd0, 0);
    run_cmd(3'd1, NC, 0, 32'h0, 16'd0, 0);
    run_cmd(3'd0, NC, 0, 32'h3333_4444, 16'd0, 0);

    drain();
    hold_cycles = 8;
    sched[0] = 32'hCAFE_F00D;
    run_cmd(3'd1, 3, 0, 32'h0, 16'd0, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      r_op = (sel < 2) ? 3'd0 : (sel == 2) ? 3'd1 : (sel < 5) ? 3'd2 : (sel < 7) ? 3'd3 :
             (sel < 9) ? 3'd4 : 3'($urandom_range(5, 7));
      r_ch   = ($urandom_range(0, 9) == 0) ? $urandom_range(NC, 7) : $urandom_range(0, NC - 1);
      r_bit  = $urandom_range(0, 31);
      r_data = $urandom;
      r_tmo  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      r_ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
      sched_len = 40;
      for (int k = 0; k <= 40; k++)
        sched[k] = (r_op == 3'd2 && $urandom_range(0, 3) == 0) ? r_data : $urandom;
      if (r_tmo == 0) begin
        if (r_op == 3'd2) sched[40] = r_data;
        if (r_op == 3'd3) begin sched[39][r_bit] = 1'b0; sched[40][r_bit] = 1'b1; end
        if (r_op == 3'd4) begin sched[39][r_bit] = 1'b1; sched[40][r_bit] = 1'b0; end
      end
      run_cmd(r_op, r_ch, r_bit, r_data, r_tmo, r_ab);
    end

    sched_len = 1; sched[0] = '0; sched[1] = '0;
    run_cmd(3'd0, 4, 0, 32'h0BAD_F00D, 16'd0, 0);
    drain();
    @(negedge clk);
    cmd_op = 3'd2; cmd_ch = 3'd2; cmd_bit = '0; cmd_data = 32'h1234_5678; cmd_timeout = '0;
    obs_drive(2, 32'h0);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_drv", drv_o, '0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    sbq.delete();
    for (int c = 0; c < NC; c++) drv_m[c] = '0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_release_cmd_ready", cmd_ready, 1'b1);
    sched[0] = 32'h0000_0042;
    run_cmd(3'd1, 2, 0, 32'h0, 16'd0, 0);
    run_cmd(3'd0, 0, 0, 32'h7777_8888, 16'd0, 0);
    drain();

    s_cmd(3'd0, 2'd1, 4'd0, 12'hABC, 8'd0, 2'd0, 0);
    s_cmd(3'd7, 2'd0, 4'd0, 12'h123, 8'd0, 2'd2, 0);
    s_cmd(3'd1, 2'd3, 4'd0, 12'h0, 8'd0, 2'd2, 0);
    s_cmd(3'd3, 2'd0, 4'd12, 12'h0, 8'd5, 2'd2, 0);
    s_cmd(3'd4, 2'd2, 4'd15, 12'h0, 8'd5, 2'd2, 0);
    s_cmd(3'd3, 2'd2, 4'd11, 12'h0, 8'd3, 2'd1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
